// File: rtl/alu_check_pkg.sv
// Shared definitions for the ALU response checker: op encoding, FSM states, expectation entry.
// The expectation entry carries flag bits only when CHECK_FLAGS_EN is defined.
package alu_check_pkg;

    localparam int unsigned ALU_W = 16;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;
    localparam int unsigned OP_INV = 2;

    typedef logic [ALU_W-1:0] word_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        word_t      a;
        word_t      b;
        logic [2:0] op;
        word_t      exp_result;
`ifdef CHECK_FLAGS_EN
        logic       exp_cout;
        logic       exp_ovf;
        logic       exp_zero;
`endif
    } exp_entry_t;

endpackage

// File: rtl/alu_checker_if.sv
// Issue and response bus between the ALU stimulus side (master) and the checker (slave).
interface alu_checker_if
    import alu_check_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             dut_valid;
    logic [WIDTH-1:0] dut_result;
    logic             dut_cout;
    logic             dut_overflow;
    logic             dut_zero;

    modport master (
        output in_valid, in_a, in_b, in_op,
        output dut_valid, dut_result, dut_cout, dut_overflow, dut_zero,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op,
        input  dut_valid, dut_result, dut_cout, dut_overflow, dut_zero,
        output in_ready
    );

endinterface

// File: rtl/alu_golden.sv
// Combinational golden ALU model: AND/OR/ADD/SLT with optional b inversion and carry-in.
module alu_golden
    import alu_check_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] sum;
    logic             set;

    // NOTE: combinational logic uses blocking '=' so later lines see earlier values in the same pass.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        result     = '0;
        bb         = op[OP_INV] ? ~b : b;
        {cout, sum} = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, op[OP_INV]};
        overflow   = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        set        = sum[WIDTH-1] ^ overflow;
        case (op[1:0])
            OP_AND:  result = a & bb;
            OP_OR:   result = a | bb;
            OP_ADD:  result = sum;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, set};
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_checker.sv
// Self-checking response end of the ALU bus: queues golden expectations, compares responses.
// Optional macro CHECK_FLAGS_EN also compares cout/overflow/zero. WIDTH must equal ALU_W.
module alu_checker
    import alu_check_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_checker_if.slave     bus,
    input  logic             halt_on_fail,
    input  logic             clear,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             mismatch,
    output logic             orphan,
    output logic             halted,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [2:0]       fail_op,
    output logic [WIDTH-1:0] fail_exp,
    output logic [WIDTH-1:0] fail_got
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W:0] occ_t;
    localparam occ_t FULL_OCC = occ_t'(DEPTH);

    exp_entry_t       mem_q [DEPTH];
    exp_entry_t       wr_entry, head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    occ_t             occ_q, occ_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] pass_count_q, pass_count_d, fail_count_q, fail_count_d;
    logic             mismatch_q, mismatch_d, orphan_q, orphan_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;
    logic [WIDTH-1:0] fail_exp_q, fail_exp_d, fail_got_q, fail_got_d;
    logic [2:0]       fail_op_q, fail_op_d;

    logic [WIDTH-1:0] gold_result;
    logic             gold_cout, gold_ovf, gold_zero;
    logic             empty, full, ready, push, pop, diff, fail_now, pass_now;

    alu_golden #(.WIDTH(WIDTH)) u_golden (
        .a        (bus.in_a),
        .b        (bus.in_b),
        .op       (bus.in_op),
        .result   (gold_result),
        .cout     (gold_cout),
        .overflow (gold_ovf),
        .zero     (gold_zero)
    );

    assign empty        = (occ_q == '0);
    assign full         = (occ_q == FULL_OCC);
    assign ready        = !full && (state_q == RUN);
    assign bus.in_ready = ready;
    // clear wins over any same-cycle push or pop
    assign push         = bus.in_valid && ready && !clear;
    assign pop          = bus.dut_valid && !empty && !clear;
    assign head         = mem_q[rd_ptr_q];

    always_comb begin
        wr_entry            = '0;
        wr_entry.a          = bus.in_a;
        wr_entry.b          = bus.in_b;
        wr_entry.op         = bus.in_op;
        wr_entry.exp_result = gold_result;
`ifdef CHECK_FLAGS_EN
        wr_entry.exp_cout   = gold_cout;
        wr_entry.exp_ovf    = gold_ovf;
        wr_entry.exp_zero   = gold_zero;
        diff = (bus.dut_result != head.exp_result) || (bus.dut_cout != head.exp_cout) ||
               (bus.dut_overflow != head.exp_ovf) || (bus.dut_zero != head.exp_zero);
`else
        diff = (bus.dut_result != head.exp_result);
`endif
    end

`ifndef CHECK_FLAGS_EN
    logic unused_flags;
    assign unused_flags = ^{gold_cout, gold_ovf, gold_zero, bus.dut_cout, bus.dut_overflow, bus.dut_zero};
`endif

    assign fail_now = pop && diff;
    assign pass_now = pop && !diff;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      occ_d = occ_q + 1'b1;
            else if (pop && !push) occ_d = occ_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (fail_now && halt_on_fail) state_d = HALT;
                HALT:    state_d = HALT;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        pass_count_d = pass_count_q;
        fail_count_d = fail_count_q;
        mismatch_d   = mismatch_q;
        orphan_d     = orphan_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;
        fail_op_d    = fail_op_q;
        fail_exp_d   = fail_exp_q;
        fail_got_d   = fail_got_q;
        if (clear) begin
            pass_count_d = '0;
            fail_count_d = '0;
            mismatch_d   = 1'b0;
            orphan_d     = 1'b0;
            fail_a_d     = '0;
            fail_b_d     = '0;
            fail_op_d    = '0;
            fail_exp_d   = '0;
            fail_got_d   = '0;
        end else begin
            if (pass_now && (pass_count_q != '1)) pass_count_d = pass_count_q + 1'b1;
            if (fail_now && (fail_count_q != '1)) fail_count_d = fail_count_q + 1'b1;
            if (bus.dut_valid && empty) orphan_d = 1'b1;
            if (fail_now) begin
                mismatch_d = 1'b1;
                // debug snapshot keeps only the first mismatch since the last clear
                if (!mismatch_q) begin
                    fail_a_d   = head.a;
                    fail_b_d   = head.b;
                    fail_op_d  = head.op;
                    fail_exp_d = head.exp_result;
                    fail_got_d = bus.dut_result;
                end
            end
        end
    end

    // NOTE: FIFO storage has no reset; occupancy and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            state_q      <= RUN;
            pass_count_q <= '0;
            fail_count_q <= '0;
            mismatch_q   <= 1'b0;
            orphan_q     <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_op_q    <= '0;
            fail_exp_q   <= '0;
            fail_got_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            state_q      <= state_d;
            pass_count_q <= pass_count_d;
            fail_count_q <= fail_count_d;
            mismatch_q   <= mismatch_d;
            orphan_q     <= orphan_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
            fail_op_q    <= fail_op_d;
            fail_exp_q   <= fail_exp_d;
            fail_got_q   <= fail_got_d;
        end
    end

    assign pass_count = pass_count_q;
    assign fail_count = fail_count_q;
    assign mismatch   = mismatch_q;
    assign orphan     = orphan_q;
    assign halted     = (state_q == HALT);
    assign fail_a     = fail_a_q;
    assign fail_b     = fail_b_q;
    assign fail_op    = fail_op_q;
    assign fail_exp   = fail_exp_q;
    assign fail_got   = fail_got_q;

endmodule
